bp_update_sched: RTL

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

---
 rtl/bp_pkg.sv | 66 ++++++
 rtl/bp_update_sched_if.sv | 39 +++
 rtl/bp_update_fifo.sv | 50 +++++
 rtl/bp_update_sched.sv | 102 ++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update scheduler: FSM states, the queued
// event record, and the registered output bundle.
package bp_pkg;

    localparam int BP_XLEN        = 32;
    localparam int BP_PHT_ADDRESS = 9;
    localparam int BP_GHR_SIZE    = 9;
    localparam int BP_RAS_ADDRESS = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_RECOVER
    } bp_state_e;

    typedef struct packed {
        logic [BP_XLEN-1:0]        pc;
        logic [BP_XLEN-1:0]        target;
        logic [BP_XLEN-1:0]        return_addr;
        logic [BP_GHR_SIZE-1:0]    ghr_snap;
        logic [BP_PHT_ADDRESS-1:0] pht_index;
        logic [BP_RAS_ADDRESS-1:0] sp_snap;
        logic [2*BP_XLEN-1:0]      ras_snap;
    } bp_payload_t;

    typedef struct packed {
        bp_payload_t pl;
        logic        is_branch;
        logic        is_jump;
        logic        is_call;
        logic        is_ret;
        logic        taken;
    } bp_update_t;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic        mispredict;
        logic        restore_ghr;
        logic        restore_ras;
        logic        pht;
        logic        btb;
        logic        ras;
        logic        is_ret;
        logic        is_branch;
        bp_payload_t pl;
    } bp_upd_out_t;

    // Predictor write strobes for one resolved event; restores only on a mispredict.
    function automatic bp_upd_out_t bp_strobe(input bp_update_t e, input logic misp);
        bp_upd_out_t o;
        o.valid       = 1'b1;
        o.taken       = e.taken;
        o.mispredict  = misp;
        o.restore_ghr = misp;
        o.restore_ras = misp;
        o.pht         = e.is_branch;
        o.btb         = e.taken && (e.is_branch || e.is_jump);
        o.ras         = e.is_call || e.is_ret;
        o.is_ret      = e.is_ret;
        o.is_branch   = e.is_branch;
        o.pl          = e.pl;
        return o;
    endfunction

endpackage

// File: rtl/bp_update_sched_if.sv
// EX-side event bus and predictor update bus of the update scheduler.
interface bp_update_sched_if #(
    parameter int XLEN        = 32,
    parameter int PHT_ADDRESS = 9,
    parameter int GHR_SIZE    = 9,
    parameter int RAS_ADDRESS = 3
);
    logic                   ex_valid, ex_is_branch, ex_is_jump, ex_is_call, ex_is_ret;
    logic                   ex_taken, ex_mispredict, ex_ready;
    logic [XLEN-1:0]        ex_pc, ex_target, ex_return_addr;
    logic [GHR_SIZE-1:0]    ex_ghr_snap;
    logic [PHT_ADDRESS-1:0] ex_pht_index;
    logic [RAS_ADDRESS-1:0] ex_sp_snap;
    logic [2*XLEN-1:0]      ex_ras_snap;

    logic                   upd_valid, upd_taken, upd_mispredict, upd_restore_ghr, upd_restore_ras;
    logic                   upd_pht, upd_btb, upd_ras, upd_is_ret, upd_is_branch, fe_stall;
    logic [XLEN-1:0]        upd_pc, upd_target, upd_return_addr;
    logic [GHR_SIZE-1:0]    upd_ghr_snap;
    logic [PHT_ADDRESS-1:0] upd_pht_index;
    logic [RAS_ADDRESS-1:0] upd_sp_snap;
    logic [2*XLEN-1:0]      upd_ras_snap;

    modport master (
        output ex_valid, ex_is_branch, ex_is_jump, ex_is_call, ex_is_ret, ex_taken, ex_mispredict,
               ex_pc, ex_target, ex_return_addr, ex_ghr_snap, ex_pht_index, ex_sp_snap, ex_ras_snap,
        input  ex_ready, upd_valid, upd_taken, upd_mispredict, upd_restore_ghr, upd_restore_ras,
               upd_pht, upd_btb, upd_ras, upd_is_ret, upd_is_branch, fe_stall,
               upd_pc, upd_target, upd_return_addr, upd_ghr_snap, upd_pht_index, upd_sp_snap, upd_ras_snap
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jump, ex_is_call, ex_is_ret, ex_taken, ex_mispredict,
               ex_pc, ex_target, ex_return_addr, ex_ghr_snap, ex_pht_index, ex_sp_snap, ex_ras_snap,
        output ex_ready, upd_valid, upd_taken, upd_mispredict, upd_restore_ghr, upd_restore_ras,
               upd_pht, upd_btb, upd_ras, upd_is_ret, upd_is_branch, fe_stall,
               upd_pc, upd_target, upd_return_addr, upd_ghr_snap, upd_pht_index, upd_sp_snap, upd_ras_snap
    );
endinterface

// File: rtl/bp_update_fifo.sv
// DEPTH-entry circular queue of resolved non-mispredict events; DEPTH must be a power of 2.
module bp_update_fifo import bp_pkg::*; #(
    parameter int  DEPTH = 4,
    parameter type T     = bp_update_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (cnt_q != '0);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/bp_update_sched.sv
// Serialises resolved control-flow events onto the predictor update ports; mispredicts bypass
// the queue and take a one-cycle restore slot. Optional macro BP_SCHED_BYPASS_EN: idle fast path.
module bp_update_sched import bp_pkg::*; #(
    parameter int XLEN        = BP_XLEN,
    parameter int PHT_ADDRESS = BP_PHT_ADDRESS,
    parameter int GHR_SIZE    = BP_GHR_SIZE,
    parameter int RAS_ADDRESS = BP_RAS_ADDRESS,
    parameter int DEPTH       = 4
) (
    input  logic             CLK,
    input  logic             reset,
    bp_update_sched_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    bp_state_e   state_q, state_d;
    bp_upd_out_t out_q, out_d;
    bp_update_t  ex_ent, head;
    logic [CW-1:0] count, cnt_nxt;
    logic        full, push, pop, misp_acc, byp;

    always_comb begin
        ex_ent.pl.pc          = XLEN'(bus.ex_pc);
        ex_ent.pl.target      = XLEN'(bus.ex_target);
        ex_ent.pl.return_addr = XLEN'(bus.ex_return_addr);
        ex_ent.pl.ghr_snap    = GHR_SIZE'(bus.ex_ghr_snap);
        ex_ent.pl.pht_index   = PHT_ADDRESS'(bus.ex_pht_index);
        ex_ent.pl.sp_snap     = RAS_ADDRESS'(bus.ex_sp_snap);
        ex_ent.pl.ras_snap    = (2*XLEN)'(bus.ex_ras_snap);
        ex_ent.is_branch      = bus.ex_is_branch;
        ex_ent.is_jump        = bus.ex_is_jump;
        ex_ent.is_call        = bus.ex_is_call;
        ex_ent.is_ret         = bus.ex_is_ret;
        ex_ent.taken          = bus.ex_taken;
    end

    assign misp_acc = bus.ex_valid && bus.ex_mispredict;
`ifdef BP_SCHED_BYPASS_EN
    // IDLE guarantees an empty queue, so the event can go straight to the output register.
    assign byp = bus.ex_valid && !bus.ex_mispredict && (state_q == S_IDLE);
`else
    assign byp = 1'b0;
`endif
    assign push    = bus.ex_valid && !bus.ex_mispredict && !full && !byp;
    assign pop     = (state_q == S_DRAIN) && !misp_acc;
    assign cnt_nxt = count + CW'(push) - CW'(pop);

    bp_update_fifo #(.DEPTH(DEPTH), .T(bp_update_t)) u_fifo (
        .clk_i   (CLK),
        .rst_i   (reset),
        .push_i  (push),
        .data_i  (ex_ent),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count),
        .full_o  (full)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // A mispredict pre-empts the drain slot; the head entry stays queued until after RECOVER.
    always_comb begin
        state_d = (cnt_nxt != '0) ? S_DRAIN : S_IDLE;
        out_d   = '0;
        if (misp_acc) begin
            state_d = S_RECOVER;
            out_d   = bp_strobe(ex_ent, 1'b1);
        end else if (pop) begin
            out_d = bp_strobe(head, 1'b0);
        end else if (byp) begin
            out_d = bp_strobe(ex_ent, 1'b0);
        end
    end

    assign bus.ex_ready        = !full;
    assign bus.fe_stall        = (state_q == S_RECOVER);
    assign bus.upd_valid       = out_q.valid;
    assign bus.upd_taken       = out_q.taken;
    assign bus.upd_mispredict  = out_q.mispredict;
    assign bus.upd_restore_ghr = out_q.restore_ghr;
    assign bus.upd_restore_ras = out_q.restore_ras;
    assign bus.upd_pht         = out_q.pht;
    assign bus.upd_btb         = out_q.btb;
    assign bus.upd_ras         = out_q.ras;
    assign bus.upd_is_ret      = out_q.is_ret;
    assign bus.upd_is_branch   = out_q.is_branch;
    assign bus.upd_pc          = XLEN'(out_q.pl.pc);
    assign bus.upd_target      = XLEN'(out_q.pl.target);
    assign bus.upd_return_addr = XLEN'(out_q.pl.return_addr);
    assign bus.upd_ghr_snap    = GHR_SIZE'(out_q.pl.ghr_snap);
    assign bus.upd_pht_index   = PHT_ADDRESS'(out_q.pl.pht_index);
    assign bus.upd_sp_snap     = RAS_ADDRESS'(out_q.pl.sp_snap);
    assign bus.upd_ras_snap    = (2*XLEN)'(out_q.pl.ras_snap);
endmodule
